// File: rtl/onebit_pkg.sv
// Shared types and constants for the one-bit SRAM access sequencer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
// Optional macro ONEBIT_DIFF_READ_EN adds the second (QB) sensing pass states.
package onebit_pkg;

   localparam int PRE_CYC_DEF = 1;
   localparam int WL_CYC_DEF  = 2;
   localparam int WR_CYC_DEF  = 2;

`ifdef ONEBIT_DIFF_READ_EN
   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ACT, S_SENSE, S_DONE, S_PRE2, S_ACT2, S_SENSE2
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ACT, S_SENSE, S_DONE
   } state_e;
`endif

   // Cell control bundle, one bit per control line.
   typedef struct packed {
      logic preb;
      logic w_en;
      logic write_bit;
      logic sae;
      logic wl;
      logic wlb;
   } ctrl_t;

   // Idle: bit lines precharged (preb low), everything else off.
   localparam ctrl_t CTRL_IDLE = '{preb: 1'b0, w_en: 1'b0, write_bit: 1'b0,
                                   sae: 1'b0, wl: 1'b0, wlb: 1'b0};

   // Phase counter width: enough to hold the longest phase length.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/onebit_access_ctrl_phase_cnt.sv
// Loadable down-counter timing every multi-cycle phase of an access.
// Latency: load takes effect on the next edge; done is a decode of the count register.
// Backpressure: none; the counter free-runs down to zero and parks there.
// Ports: clk, rst_n, load/load_val (start a phase of load_val+1 cycles), done (count at zero).
module onebit_phase_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/onebit_access_ctrl.sv
// Sequences a valid/ready read or write into phased one-bit cell controls and returns a response.
// Latency: write rsp after E0+PRE_CYC+WR_CYC, read after E0+PRE_CYC+WL_CYC+1 (doubled sensing with macro).
// Backpressure: req_ready high only in IDLE; one request in flight, at least one idle cycle between.
// Ports: req_* request channel, rsp_* response pulse, sa_out sense-amp input, preb/w_en/write_bit/SAE/WL/WLB cell controls.
// Macro ONEBIT_DIFF_READ_EN: reads sense Q then QB and flag a non-complementary pair on rsp_err.
module onebit_access_ctrl
   import onebit_pkg::*;
#(
   parameter int PRE_CYC = PRE_CYC_DEF,
   parameter int WL_CYC  = WL_CYC_DEF,
   parameter int WR_CYC  = WR_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_we,
   input  logic req_wdata,
   input  logic req_sel,
   input  logic sa_out,
   output logic rsp_valid,
   output logic rsp_data,
   output logic rsp_err,
   output logic preb,
   output logic w_en,
   output logic write_bit,
   output logic SAE,
   output logic WL,
   output logic WLB
);

   if (PRE_CYC < 1 || WL_CYC < 1 || WR_CYC < 1) begin : g_bad_param
      $error("onebit_access_ctrl: phase lengths must be at least 1");
   end

   localparam int CW = cnt_width(PRE_CYC, WL_CYC, WR_CYC);
   localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC - 1);
   localparam logic [CW-1:0] WL_LD  = CW'(WL_CYC - 1);
   localparam logic [CW-1:0] WR_LD  = CW'(WR_CYC - 1);

   state_e          state_q, state_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic            cnt_load, cnt_done;
   logic [CW-1:0]   cnt_ld_val;
   logic            we_q, we_d, wdata_q, wdata_d;
   logic            req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic            rsp_data_q, rsp_data_d;
`ifdef ONEBIT_DIFF_READ_EN
   logic            samp_q, samp_d, rsp_err_q, rsp_err_d;
`else
   logic            sel_q, sel_d;
`endif

   // Each phase counter load happens on the edge that enters the phase.
   assign cnt_load = (state_d != state_q);
   always_comb begin
      cnt_ld_val = '0;
      case (state_d)
         S_PRE:   cnt_ld_val = PRE_LD;
         S_ACT:   cnt_ld_val = we_q ? WR_LD : WL_LD;
`ifdef ONEBIT_DIFF_READ_EN
         S_PRE2:  cnt_ld_val = PRE_LD;
         S_ACT2:  cnt_ld_val = WL_LD;
`endif
         default: cnt_ld_val = '0;
      endcase
   end

   onebit_phase_cnt #(.W(CW)) u_phase_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_ld_val),
      .done     (cnt_done)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req_valid) state_d = S_PRE;
         S_PRE:    if (cnt_done) state_d = S_ACT;
         S_ACT:    if (cnt_done) state_d = we_q ? S_DONE : S_SENSE;
`ifdef ONEBIT_DIFF_READ_EN
         S_SENSE:  state_d = S_PRE2;
         S_PRE2:   if (cnt_done) state_d = S_ACT2;
         S_ACT2:   if (cnt_done) state_d = S_SENSE2;
         S_SENSE2: state_d = S_DONE;
`else
         S_SENSE:  state_d = S_DONE;
`endif
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output logic: decoded from the next state so every control is a flop output.
   always_comb begin
      ctrl_d      = CTRL_IDLE;
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_DONE);
      case (state_d)
         S_ACT, S_SENSE: begin
            ctrl_d.preb = 1'b1;
            if (we_q) begin
               ctrl_d.w_en      = 1'b1;
               ctrl_d.write_bit = wdata_q;
               ctrl_d.wl        = 1'b1;
               ctrl_d.wlb       = 1'b1;
            end else begin
               ctrl_d.sae = (state_d == S_SENSE);
`ifdef ONEBIT_DIFF_READ_EN
               ctrl_d.wl  = 1'b1;
`else
               ctrl_d.wl  = !sel_q;
               ctrl_d.wlb = sel_q;
`endif
            end
         end
`ifdef ONEBIT_DIFF_READ_EN
         S_ACT2, S_SENSE2: begin
            ctrl_d.preb = 1'b1;
            ctrl_d.wlb  = 1'b1;
            ctrl_d.sae  = (state_d == S_SENSE2);
         end
`endif
         default: ctrl_d = CTRL_IDLE;
      endcase
   end

   // Request latch and response datapath
   always_comb begin
      we_d       = we_q;
      wdata_d    = wdata_q;
      rsp_data_d = rsp_data_q;
`ifdef ONEBIT_DIFF_READ_EN
      samp_d     = samp_q;
      rsp_err_d  = rsp_err_q;
`else
      sel_d      = sel_q;
`endif
      if (state_q == S_IDLE && req_valid) begin
         we_d    = req_we;
         wdata_d = req_wdata;
`ifndef ONEBIT_DIFF_READ_EN
         sel_d   = req_sel;
`endif
      end
      if (state_q == S_ACT && state_d == S_DONE) begin
         rsp_data_d = wdata_q;
`ifdef ONEBIT_DIFF_READ_EN
         rsp_err_d  = 1'b0;
`endif
      end
`ifdef ONEBIT_DIFF_READ_EN
      if (state_q == S_SENSE) samp_d = sa_out;
      // A healthy cell yields complementary Q/QB samples.
      if (state_q == S_SENSE2) begin
         rsp_data_d = samp_q;
         rsp_err_d  = (sa_out == samp_q);
      end
`else
      // QB port reads the complement; flip back to true polarity.
      if (state_q == S_SENSE) rsp_data_d = sa_out ^ sel_q;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q      <= CTRL_IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= 1'b0;
`ifdef ONEBIT_DIFF_READ_EN
         samp_q      <= 1'b0;
         rsp_err_q   <= 1'b0;
`else
         sel_q       <= 1'b0;
`endif
      end else begin
         ctrl_q      <= ctrl_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
`ifdef ONEBIT_DIFF_READ_EN
         samp_q      <= samp_d;
         rsp_err_q   <= rsp_err_d;
`else
         sel_q       <= sel_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
`ifdef ONEBIT_DIFF_READ_EN
   assign rsp_err   = rsp_err_q;
`else
   assign rsp_err   = 1'b0;
`endif
   assign preb      = ctrl_q.preb;
   assign w_en      = ctrl_q.w_en;
   assign write_bit = ctrl_q.write_bit;
   assign SAE       = ctrl_q.sae;
   assign WL        = ctrl_q.wl;
   assign WLB       = ctrl_q.wlb;

   a_wl_needs_preb: assert property (@(posedge clk) disable iff (!rst_n) !((WL || WLB) && !preb));
   a_sae_excl_wen:  assert property (@(posedge clk) disable iff (!rst_n) !(SAE && w_en));
   a_both_wl_write: assert property (@(posedge clk) disable iff (!rst_n) !(WL && WLB && !w_en));

endmodule

// File: tb/tb_onebit_access_ctrl.sv
module tb_onebit_access_ctrl;

   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid = 1'b0, req_we = 1'b0, req_wdata = 1'b0, req_sel = 1'b0, sa_out = 1'b0;
   logic req_ready, rsp_valid, rsp_data, rsp_err;
   logic preb, w_en, write_bit, SAE, WL, WLB;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   onebit_access_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_wdata(req_wdata), .req_sel(req_sel), .sa_out(sa_out),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .preb(preb), .w_en(w_en), .write_bit(write_bit), .SAE(SAE), .WL(WL), .WLB(WLB)
   );

   // {preb,w_en,write_bit,SAE,WL,WLB,req_ready,rsp_valid}
   function automatic logic [7:0] obs();
      return {preb, w_en, write_bit, SAE, WL, WLB, req_ready, rsp_valid};
   endfunction

   // Drive one request from a negedge; returns at the negedge after acceptance edge E0.
   task automatic issue(input logic we, input logic wd, input logic sel, output bit ok);
      int n = 0;
      while (!req_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      req_we = we; req_wdata = wd; req_sel = sel; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if ({obs(), rsp_data, rsp_err} !== 10'b0000_0010_00) begin
         fails++;
         $display("FAIL reset_values: got %b, want 0000001000", {obs(), rsp_data, rsp_err});
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (obs() !== 8'b0000_0010) begin
         fails++;
         $display("FAIL reset_release: got %b, want 00000010", obs());
      end
   endtask

   task automatic test_inv_read();
      logic [8:0] exp_w [5];
      logic [8:0] exp_r [6];
      bit ok;
      exp_w = '{9'b0000_0000_0, 9'b1110_1100_0, 9'b1110_1100_0, 9'b0000_0001_1, 9'b0000_0010_1};
      exp_r = '{9'b0000_0000_1, 9'b1000_0100_1, 9'b1000_0100_1, 9'b1001_0100_1,
                9'b0000_0001_1, 9'b0000_0010_1};
      issue(1'b1, 1'b1, 1'b0, ok);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         tests++;
         if ({obs(), rsp_data} !== exp_w[k] || !ok) begin
            fails++;
            $display("FAIL inv_write k=%0d: got %b, want %b", k, {obs(), rsp_data}, exp_w[k]);
         end
      end
      sa_out = 1'b0;
      issue(1'b0, 1'b0, 1'b1, ok);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         tests++;
         if ({obs(), rsp_data} !== exp_r[k] || !ok) begin
            fails++;
            $display("FAIL inv_read k=%0d: got %b, want %b", k, {obs(), rsp_data}, exp_r[k]);
         end
      end
   endtask

   task automatic test_write_read();
      logic [8:0] exp_w [5];
      logic [8:0] exp_r [6];
      bit ok;
      exp_w = '{9'b0000_0000_1, 9'b1100_1100_1, 9'b1100_1100_1, 9'b0000_0001_0, 9'b0000_0010_0};
      exp_r = '{9'b0000_0000_0, 9'b1000_1000_0, 9'b1000_1000_0, 9'b1001_1000_0,
                9'b0000_0001_0, 9'b0000_0010_0};
      issue(1'b1, 1'b0, 1'b0, ok);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         tests++;
         if ({obs(), rsp_data} !== exp_w[k] || !ok) begin
            fails++;
            $display("FAIL write0 k=%0d: got %b, want %b", k, {obs(), rsp_data}, exp_w[k]);
         end
      end
      sa_out = 1'b0;
      issue(1'b0, 1'b0, 1'b0, ok);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         tests++;
         if ({obs(), rsp_data, rsp_err} !== {exp_r[k], 1'b0} || !ok) begin
            fails++;
            $display("FAIL read_q k=%0d: got %b, want %b0", k, {obs(), rsp_data, rsp_err}, exp_r[k]);
         end
      end
   endtask

   task automatic test_read_patterns();
      logic [2:0] pat [4];  // {sel, sa_out, expected data}
      bit ok;
      pat = '{3'b011, 3'b110, 3'b101, 3'b000};
      for (int i = 0; i < 4; i++) begin
         logic [2:0] p;
         p = pat[i];
         sa_out = p[1];
         issue(1'b0, 1'b1, p[2], ok);
         repeat (3) @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b0 || !ok) begin
            fails++;
            $display("FAIL read_early_%0d: rsp_valid=%b at E3, want 0", i, rsp_valid);
         end
         @(negedge clk);
         tests++;
         if ({rsp_valid, rsp_data} !== {1'b1, p[0]}) begin
            fails++;
            $display("FAIL read_pat_%0d: valid/data=%b%b, want 1%b", i, rsp_valid, rsp_data, p[0]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_busy();
      logic [2:0] exp [7];  // {req_ready, rsp_valid, WL}
      exp = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000, 3'b001};
      req_we = 1'b1; req_wdata = 1'b1; req_sel = 1'b0; req_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         tests++;
         if ({req_ready, rsp_valid, WL} !== exp[k]) begin
            fails++;
            $display("FAIL busy k=%0d: ready/valid/WL=%b, want %b", k, {req_ready, rsp_valid, WL}, exp[k]);
         end
      end
      req_valid = 1'b0;
      for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok, seen;
      sa_out = 1'b1;
      issue(1'b0, 1'b0, 1'b0, ok);
      @(negedge clk);
      tests++;
      if (WL !== 1'b1 || !ok) begin
         fails++;
         $display("FAIL rst_mid_act: WL=%b before reset, want 1", WL);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({obs(), rsp_data} !== 9'b0000_0010_0) begin
         fails++;
         $display("FAIL rst_mid_async: got %b, want 000000100", {obs(), rsp_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (req_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_ready: req_ready=%b, want 1", req_ready);
      end
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL rst_mid_no_rsp: rsp_valid=1 seen, want none");
      end
   endtask

`ifdef ONEBIT_DIFF_READ_EN
   task automatic test_diff();
      bit ok;
      for (int r = 0; r < 2; r++) begin
         sa_out = 1'b1;
         issue(1'b0, 1'b0, 1'b1, ok);
         @(negedge clk);
         tests++;
         if ({WL, WLB} !== 2'b10 || !ok) begin
            fails++;
            $display("FAIL diff_q_phase_%0d: WL/WLB=%b, want 10", r, {WL, WLB});
         end
         repeat (3) @(negedge clk);
         if (r == 0) sa_out = 1'b0;
         @(negedge clk);
         tests++;
         if ({WL, WLB} !== 2'b01) begin
            fails++;
            $display("FAIL diff_qb_phase_%0d: WL/WLB=%b, want 01", r, {WL, WLB});
         end
         repeat (2) @(negedge clk);
         tests++;
         if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL diff_early_%0d: rsp_valid=%b at E7, want 0", r, rsp_valid);
         end
         @(negedge clk);
         tests++;
         if ({rsp_valid, rsp_data, rsp_err} !== {2'b11, (r == 1)}) begin
            fails++;
            $display("FAIL diff_rsp_%0d: valid/data/err=%b, want 11%0d", r,
                     {rsp_valid, rsp_data, rsp_err}, r);
         end
         @(negedge clk);
      end
   endtask
`endif

   task automatic test_random();
      bit ok, got, bad;
      logic we, wd, sel, sa, exp_d, exp_e, got_d, got_e;
      for (int n = 0; n < 500; n++) begin
         we = 1'($urandom_range(0, 1)); wd = 1'($urandom_range(0, 1));
         sel = 1'($urandom_range(0, 1)); sa = 1'($urandom_range(0, 1));
`ifdef ONEBIT_DIFF_READ_EN
         exp_d = we ? wd : sa;
         exp_e = !we;
`else
         exp_d = we ? wd : (sa ^ sel);
         exp_e = 1'b0;
`endif
         sa_out = sa;
         issue(we, wd, sel, ok);
         got = 1'b0; bad = 1'b0; got_d = 1'b0; got_e = 1'b0;
         for (int c = 0; c < 20 && !got; c++) begin
            if (((WL || WLB) && !preb) || (SAE && w_en) || (WL && WLB && !w_en) ||
                (write_bit && !w_en) || req_ready)
               bad = 1'b1;
            if (rsp_valid) begin
               got = 1'b1; got_d = rsp_data; got_e = rsp_err;
               req_valid = 1'b0;
            end else begin
               // Noise on the request channel while busy must be ignored.
               req_valid = 1'($urandom_range(0, 1));
               req_we = 1'($urandom_range(0, 1)); req_wdata = 1'($urandom_range(0, 1));
               req_sel = 1'($urandom_range(0, 1));
               @(negedge clk);
            end
         end
         req_valid = 1'b0;
         tests++;
         if (!ok || !got || got_d !== exp_d || got_e !== exp_e) begin
            fails++;
            $display("FAIL rand_rsp_%0d: got rsp=%b data=%b err=%b, want rsp=1 data=%b err=%b",
                     n, got, got_d, got_e, exp_d, exp_e);
         end
         tests++;
         if (bad) begin
            fails++;
            $display("FAIL rand_invariant_%0d: illegal control combination or ready while busy", n);
         end
         @(negedge clk);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
`ifndef ONEBIT_DIFF_READ_EN
      test_inv_read();
      test_write_read();
      test_read_patterns();
`endif
      test_busy();
      test_reset_mid();
`ifdef ONEBIT_DIFF_READ_EN
      test_diff();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
